// File: rtl/gate_code_sender.sv
`default_nettype none
// ============================================================================
// Module   : gate_code_sender
// Purpose  : Sends a latched 16-bit code to the gate controller one nibble per
//            cycle, then retries or finishes based on the green/red lamps.
// Revision : 1.0
// ============================================================================
module gate_code_sender #(
    parameter int DIGITS       = 4,
    parameter int DIGIT_W      = 5,
    parameter int MAX_RETRY    = 2,
    parameter int RESP_TIMEOUT = 16,
    parameter int RETRY_GAP    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   code,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  gate_green,
    input  logic                  gate_red,
    output logic [DIGIT_W-1:0]    pass_digit,
    output logic                  in_enable,
    output logic                  busy,
    output logic                  done,
    output logic                  accepted,
    output logic                  rejected,
    output logic                  timeout,
    output logic [1:0]            retries_used
);

    localparam int KW = $clog2(DIGITS + 2);
    localparam int TW = $clog2(RESP_TIMEOUT + 1);
    localparam int GW = (RETRY_GAP > 0) ? $clog2(RETRY_GAP + 1) : 1;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SEND      = 3'd1;
    localparam logic [2:0] ST_WAIT_RESP = 3'd2;
    localparam logic [2:0] ST_GAP       = 3'd3;
    localparam logic [2:0] ST_FIN       = 3'd4;

    logic [2:0]             state_q,      state_d;
    logic [KW-1:0]          k_q,          k_d;
    logic [TW-1:0]          tcnt_q,       tcnt_d;
    logic [GW-1:0]          gcnt_q,       gcnt_d;
    logic [4*DIGITS-1:0]    code_q,       code_d;
    logic [1:0]             retries_q,    retries_d;
    logic [DIGIT_W-1:0]     pass_digit_q, pass_digit_d;
    logic                   in_enable_q,  in_enable_d;
    logic                   busy_q,       busy_d;
    logic                   done_q,       done_d;
    logic                   accepted_q,   accepted_d;
    logic                   rejected_q,   rejected_d;
    logic                   timeout_q,    timeout_d;

    logic [3:0]             w_nibble;

    always_comb begin
        w_nibble = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (k_q == KW'(i)) begin
                w_nibble = code_q[4*i +: 4];
            end
        end
    end

    // SEND spans DIGITS+2 cycles: each edge with k<=DIGITS loads the slot shown
    // in the following cycle, and the final edge drops in_enable as the state
    // moves on to WAIT_RESP.
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        tcnt_d       = tcnt_q;
        gcnt_d       = gcnt_q;
        code_d       = code_q;
        retries_d    = retries_q;
        pass_digit_d = '0;
        in_enable_d  = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;
        accepted_d   = accepted_q;
        rejected_d   = rejected_q;
        timeout_d    = timeout_q;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start && !abort) begin
                    code_d     = code;
                    retries_d  = 2'd0;
                    accepted_d = 1'b0;
                    rejected_d = 1'b0;
                    timeout_d  = 1'b0;
                    k_d        = '0;
                    busy_d     = 1'b1;
                    state_d    = ST_SEND;
                end
            end

            ST_SEND: begin
                if (k_q <= KW'(DIGITS)) begin
                    in_enable_d  = 1'b1;
                    pass_digit_d = (k_q < KW'(DIGITS)) ? DIGIT_W'(w_nibble) : '0;
                    k_d          = k_q + KW'(1);
                end else begin
                    tcnt_d  = '0;
                    state_d = ST_WAIT_RESP;
                end
            end

            ST_WAIT_RESP: begin
                if (gate_green) begin
                    accepted_d = 1'b1;
                    done_d     = 1'b1;
                    state_d    = ST_FIN;
                end else if (gate_red && (retries_q < 2'(MAX_RETRY))) begin
                    retries_d = retries_q + 2'd1;
                    gcnt_d    = '0;
                    k_d       = '0;
                    state_d   = (RETRY_GAP == 0) ? ST_SEND : ST_GAP;
                end else if (gate_red) begin
                    rejected_d = 1'b1;
                    done_d     = 1'b1;
                    state_d    = ST_FIN;
                end else if (tcnt_q == TW'(RESP_TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = ST_FIN;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end

            ST_GAP: begin
                if (gcnt_q == GW'(RETRY_GAP - 1)) begin
                    k_d     = '0;
                    state_d = ST_SEND;
                end else begin
                    gcnt_d = gcnt_q + GW'(1);
                end
            end

            ST_FIN: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        // Abort silently drops the transaction; the retry count is kept for diagnosis.
        if (abort && (state_q != ST_IDLE)) begin
            state_d      = ST_IDLE;
            retries_d    = retries_q;
            pass_digit_d = '0;
            in_enable_d  = 1'b0;
            busy_d       = 1'b0;
            done_d       = 1'b0;
            accepted_d   = 1'b0;
            rejected_d   = 1'b0;
            timeout_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            k_q          <= '0;
            tcnt_q       <= '0;
            gcnt_q       <= '0;
            code_q       <= '0;
            retries_q    <= 2'd0;
            pass_digit_q <= '0;
            in_enable_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            accepted_q   <= 1'b0;
            rejected_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            tcnt_q       <= tcnt_d;
            gcnt_q       <= gcnt_d;
            code_q       <= code_d;
            retries_q    <= retries_d;
            pass_digit_q <= pass_digit_d;
            in_enable_q  <= in_enable_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            accepted_q   <= accepted_d;
            rejected_q   <= rejected_d;
            timeout_q    <= timeout_d;
        end
    end

    assign pass_digit   = pass_digit_q;
    assign in_enable    = in_enable_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign accepted     = accepted_q;
    assign rejected     = rejected_q;
    assign timeout      = timeout_q;
    assign retries_used = retries_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_code_sender.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_code_sender
// Purpose  : Directed self-checking bench for gate_code_sender.
// Revision : 1.0
// ============================================================================
module tb_gate_code_sender;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] code = 16'h0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        gate_green = 1'b0;
    logic        gate_red = 1'b0;
    logic [4:0]  pass_digit;
    logic        in_enable;
    logic        busy;
    logic        done;
    logic        accepted;
    logic        rejected;
    logic        timeout;
    logic [1:0]  retries_used;

    int n_pass = 0;
    int n_total = 0;

    gate_code_sender #(
        .DIGITS(4), .DIGIT_W(5), .MAX_RETRY(2), .RESP_TIMEOUT(16), .RETRY_GAP(2)
    ) dut (
        .clk(clk), .rst(rst), .code(code), .start(start), .abort(abort),
        .gate_green(gate_green), .gate_red(gate_red),
        .pass_digit(pass_digit), .in_enable(in_enable), .busy(busy), .done(done),
        .accepted(accepted), .rejected(rejected), .timeout(timeout),
        .retries_used(retries_used)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [4:0] slot_digit(input logic [15:0] c, input int k);
        logic [15:0] t;
        t = c >> (4 * k);
        return (k < 4) ? {1'b0, t[3:0]} : 5'd0;
    endfunction

    // Leaves the bench at the negedge of cycle 1 (one cycle after start is sampled).
    task automatic do_start(input logic [15:0] c);
        @(negedge clk);
        code  = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        code  = 16'h0;
        chk("busy_after_start", {15'd0, busy}, 16'd1);
        chk("en_setup_cycle", {15'd0, in_enable}, 16'd0);
    endtask

    // Five consecutive enable cycles; ends at the negedge of the compare slot.
    task automatic check_burst(input logic [15:0] c, input string tag);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            if (in_enable !== 1'b1 || pass_digit !== slot_digit(c, k)) bad = 1'b1;
        end
        chk(tag, {15'd0, bad}, 16'd0);
    endtask

    // Red in the first WAIT_RESP cycle, then the retry gap with enable low.
    task automatic red_retry(input logic [1:0] exp_retries);
        logic bad;
        bad = 1'b0;
        @(negedge clk);
        gate_red = 1'b1;
        if (in_enable !== 1'b0) bad = 1'b1;
        @(negedge clk);
        gate_red = 1'b0;
        chk("retry_count", {14'd0, retries_used}, {14'd0, exp_retries});
        if (in_enable !== 1'b0) bad = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (in_enable !== 1'b0 || done !== 1'b0) bad = 1'b1;
        end
        chk("gap_quiet", {15'd0, bad}, 16'd0);
    endtask

    task automatic green_now(input string tag, input logic [1:0] exp_retries);
        @(negedge clk);
        gate_green = 1'b1;
        @(negedge clk);
        gate_green = 1'b0;
        chk(tag, {11'd0, done, accepted, rejected, timeout, 1'b0},
            {11'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        chk("retries_at_accept", {14'd0, retries_used}, {14'd0, exp_retries});
        @(negedge clk);
        chk("fin_to_idle", {13'd0, busy, done, accepted}, {13'd0, 1'b0, 1'b0, 1'b1});
    endtask

    initial begin
        logic bad;

        // Power-on reset state
        #2 rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {pass_digit, in_enable, busy, done, accepted, rejected,
                              timeout, retries_used, 2'b00}, 16'h0);
        @(negedge clk);
        rst = 1'b1;

        // Test 1: async reset in the middle of SEND
        do_start(16'h4321);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("t1_digit_k2", {11'd0, pass_digit}, 16'h0003);
        rst = 1'b0;
        #1;
        chk("t1_async_reset", {pass_digit, in_enable, busy, done, accepted, rejected,
                               timeout, retries_used, 2'b00}, 16'h0);
        @(negedge clk);
        rst = 1'b1;
        do_start(16'h4321);
        check_burst(16'h4321, "t1_burst_from_k0");
        green_now("t1_accept", 2'd0);

        // Test 2: A3C5, green three cycles after the compare slot
        do_start(16'hA3C5);
        check_burst(16'hA3C5, "t2_burst_5C3A0");
        @(negedge clk);
        chk("t2_wait_en_low", {14'd0, in_enable, busy}, 16'h0001);
        @(negedge clk);
        chk("t2_no_early_done", {15'd0, done}, 16'd0);
        green_now("t2_accept", 2'd0);

        // Test 3: red, red, green
        do_start(16'h1234);
        check_burst(16'h1234, "t3_burst1");
        red_retry(2'd1);
        check_burst(16'h1234, "t3_burst2");
        red_retry(2'd2);
        check_burst(16'h1234, "t3_burst3");
        green_now("t3_accept", 2'd2);

        // Test 4: red on every response
        do_start(16'hBEEF);
        check_burst(16'hBEEF, "t4_burst1");
        red_retry(2'd1);
        check_burst(16'hBEEF, "t4_burst2");
        red_retry(2'd2);
        check_burst(16'hBEEF, "t4_burst3");
        @(negedge clk);
        gate_red = 1'b1;
        @(negedge clk);
        gate_red = 1'b0;
        chk("t4_reject", {11'd0, done, accepted, rejected, timeout, 1'b0},
            {11'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        chk("t4_retries", {14'd0, retries_used}, 16'd2);
        bad = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (in_enable !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad = 1'b1;
        end
        chk("t4_no_fourth_burst", {15'd0, bad}, 16'd0);
        chk("t4_flags_hold", {13'd0, rejected, retries_used}, 16'h0006);

        // Test 5: timeout, with a start during busy ignored
        do_start(16'h5A5A);
        check_burst(16'h5A5A, "t5_burst");
        @(negedge clk);
        start = 1'b1;
        code  = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        code  = 16'h0;
        bad = 1'b0;
        repeat (14) begin
            @(negedge clk);
            if (in_enable !== 1'b0 || done !== 1'b0) bad = 1'b1;
        end
        chk("t5_quiet_wait", {15'd0, bad}, 16'd0);
        @(negedge clk);
        chk("t5_timeout", {11'd0, done, accepted, rejected, timeout, 1'b0},
            {11'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (in_enable !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad = 1'b1;
        end
        chk("t5_no_extra_burst", {15'd0, bad}, 16'd0);
        chk("t5_timeout_holds", {15'd0, timeout}, 16'd1);

        // Test 6: abort during the third digit
        do_start(16'h9876);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("t6_digit_k2", {11'd0, pass_digit, in_enable}, {11'd0, 5'h08, 1'b1});
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t6_abort", {13'd0, in_enable, busy, done}, 16'd0);
        chk("t6_abort_flags", {13'd0, accepted, rejected, timeout}, 16'd0);
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (in_enable !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad = 1'b1;
        end
        chk("t6_no_done_after_abort", {15'd0, bad}, 16'd0);

        // Abort beats start in IDLE
        start = 1'b1;
        abort = 1'b1;
        code  = 16'h1111;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("t6_abort_wins", {14'd0, busy, in_enable}, 16'd0);

        // Both lamps in WAIT_RESP: green wins
        do_start(16'h0F0F);
        check_burst(16'h0F0F, "t6_burst");
        @(negedge clk);
        gate_green = 1'b1;
        gate_red   = 1'b1;
        @(negedge clk);
        gate_green = 1'b0;
        gate_red   = 1'b0;
        chk("t6_both_lamps", {11'd0, done, accepted, rejected, timeout, 1'b0},
            {11'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        chk("t6_both_retries", {14'd0, retries_used}, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/gate_code_sender.md
Name: gate_code_sender

Overview:
- Transmit side of the car-park password interface: the entry keypad/terminal block that ships a 16-bit code to the gate controller as nibble digits, one per cycle, with an enable strobe.
- Sits between the keypad entry logic and the gate controller.
- Watches the controller's green/red lamps to decide accept, retry or fail.
- Reports the outcome to the terminal.

Parameters:
- DIGITS, 4, number of 4-bit digits per code (code width = 4*DIGITS)
- DIGIT_W, 5, width of the digit bus; digits are zero-extended from 4 bits
- MAX_RETRY, 2, re-sends allowed after a red response (0..3)
- RESP_TIMEOUT, 16, cycles to wait for green/red after the last send slot
- RETRY_GAP, 2, idle cycles (enable low) before a re-send

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- code  in  4*DIGITS  code to send; sampled only on an accepted start
- start  in  1  single-cycle request; honoured only when busy=0
- abort  in  1  synchronous abort; returns to IDLE from any state
- gate_green  in  1  controller green lamp (code accepted)
- gate_red  in  1  controller red lamp (code rejected / gate stop)
- pass_digit  out  DIGIT_W  digit presented to the controller
- in_enable  out  1  digit-valid strobe; the controller's digit counter advances each cycle it is high
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at the end of a transaction
- accepted  out  1  valid with done: green seen
- rejected  out  1  valid with done: red seen with no retries left
- timeout  out  1  valid with done: neither lamp within RESP_TIMEOUT
- retries_used  out  2  re-sends performed in the current/last transaction

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs are 0: pass_digit, in_enable, busy, done, accepted, rejected, timeout, retries_used. The code latch is cleared.
- FSM states: IDLE, SEND, WAIT_RESP, GAP, FIN.
- IDLE:
  - On start=1, latch code, clear retries_used, go to SEND.
  - busy rises the next cycle.
- SEND: runs DIGITS+1 consecutive cycles with in_enable=1, indexed k=0..DIGITS.
  - Slots k<DIGITS: pass_digit = {0, code_latched[4k+3:4k]}, least-significant nibble first.
  - Slot k=DIGITS is the compare slot: pass_digit=0, in_enable=1.
  - Then go to WAIT_RESP; in_enable returns to 0 in the same edge.
  - No gaps inside SEND. All outputs are registered.
- WAIT_RESP:
  - in_enable=0. A timeout counter counts from 0 each cycle; lamps are sampled each cycle.
  - gate_green=1 → FIN with accepted. Green has priority if both lamps are high.
  - else gate_red=1 and retries_used<MAX_RETRY → retries_used+1, go to GAP.
  - else gate_red=1 → FIN with rejected.
  - else counter reaches RESP_TIMEOUT-1 → FIN with timeout.
- GAP: RETRY_GAP cycles with in_enable=0, then SEND. The code is re-sent from k=0 using the same latched code.
- FIN:
  - One cycle: done=1, with exactly one of accepted/rejected/timeout = 1.
  - Next cycle: IDLE, busy=0, done=0.
  - accepted/rejected/timeout and retries_used hold their values until the next accepted start clears them.
- start while busy=1: ignored. It is not queued and code is not resampled.
- abort=1 (any non-IDLE state): next edge goes to IDLE.
  - in_enable=0, busy=0, no done pulse.
  - Flags cleared; retries_used holds.
  - If abort and start are both high in IDLE, abort wins.
- Lamps are ignored outside WAIT_RESP. A pre-existing red from the previous transaction does not affect SEND.
- retries_used never exceeds MAX_RETRY.
- Latency with an immediate green: start at cycle 0 → in_enable cycles 2..DIGITS+2 → done at the cycle after green is sampled.

Test Plan:
1. Reset mid-SEND (rst low at k=2) → all outputs 0 immediately (async); start after release sends from k=0.
2. code=16'hA3C5, start, green asserted 3 cycles after last slot:
   - in_enable high 5 consecutive cycles.
   - pass_digit sequence 5,C,3,A,0.
   - done+accepted once, retries_used=0.
3. MAX_RETRY=2, red on first two responses, green on third:
   - three SEND bursts, each separated by ≥RETRY_GAP cycles with in_enable=0.
   - accepted=1, retries_used=2.
4. Red on all responses → 3 bursts, then done with rejected=1 and retries_used=2; no 4th burst.
5. No lamps after send → done with timeout=1 exactly RESP_TIMEOUT cycles after entering WAIT_RESP. Also: second start during busy is ignored, with no extra burst.
6. abort during the 3rd digit → next cycle in_enable=0, busy=0, no done; green and red both high in WAIT_RESP → accepted.
